// File: rtl/switch_debouncer_pkg.sv
// Shared constants and types for the slide-switch conditioning stage.
package switch_debouncer_pkg;

    // Board clock and the settle time the switches need.
    localparam int CLK_HZ      = 50_000_000;
    localparam int DEBOUNCE_MS = 10;

    // Convert a settle time in milliseconds into clock cycles.
    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

    // Default settle window: 10 ms at 50 MHz = 500000 cycles.
    localparam int DEBOUNCE_CYCLES_DEF = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);

    // Per-edge decision taken by each bit's debounce logic.
    typedef enum logic [1:0] {
        ACT_HOLD   = 2'd0,  // synchronised level agrees with clean state
        ACT_COUNT  = 2'd1,  // disagreement, still inside the settle window
        ACT_ACCEPT = 2'd2   // disagreement held for the full window
    } db_act_e;

endpackage

// File: rtl/switch_debouncer_bit.sv
// One switch bit: two-flop synchroniser followed by a stable-count debouncer.
module debounce_bit
    import switch_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic clean_o,
    output logic changed_o
);

    // Last count value before a disagreement is accepted; the counter never
    // goes past this, so it cannot wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q, clean_d;
    logic             chg_q, chg_d;
    db_act_e          act;

    // Two back-to-back flops bring the asynchronous pin into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Classify this edge: agree, keep counting, or accept the new level.
    always_comb begin
        act = ACT_HOLD;
        if (sync2_q != clean_q) begin
            act = (cnt_q == CNT_LAST) ? ACT_ACCEPT : ACT_COUNT;
        end
    end

    // Next-state: any agreement (including a glitch ending) clears the count.
    always_comb begin
        cnt_d   = '0;
        clean_d = clean_q;
        chg_d   = 1'b0;
        case (act)
            ACT_COUNT:  cnt_d = cnt_q + CNT_W'(1);
            ACT_ACCEPT: begin
                clean_d = sync2_q;
                chg_d   = 1'b1;
            end
            default: ;
        endcase
    end

    // Debounce state registers; reset discards any count in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            clean_q <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            chg_q   <= chg_d;
        end
    end

    assign clean_o   = clean_q;
    assign changed_o = chg_q;

endmodule

// File: rtl/switch_debouncer.sv
// Slide-switch conditioning: WIDTH independent synchronise+debounce lanes
// feeding the PIO in_port, plus per-bit and aggregate change strobes.
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int WIDTH           = 9,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_changed,
    output logic             any_changed
);

    logic [WIDTH-1:0] clean_w;
    logic [WIDTH-1:0] chg_w;
    logic             any_q, any_d;

    // Each bit settles on its own schedule; bits only pulse together when
    // their counts happen to finish on the same edge.
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_bit (
            .clk      (clk),
            .reset    (reset),
            .raw_i    (sw_raw[b]),
            .clean_o  (clean_w[b]),
            .changed_o(chg_w[b])
        );
    end

    // Aggregate strobe is the OR of the per-bit strobes, one edge later.
    always_comb begin
        any_d = |chg_w;
    end

    // Register the aggregate so every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            any_q <= 1'b0;
        end else begin
            any_q <= any_d;
        end
    end

    assign sw_clean    = clean_w;
    assign sw_changed  = chg_w;
    assign any_changed = any_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer: directed scenarios then random
// bouncing, checked against a window-based reference model.
module tb_switch_debouncer;

    localparam int W = 9;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_clean;
    logic [W-1:0] sw_changed;
    logic         any_changed;

    always #5 clk = ~clk;

    switch_debouncer #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_raw     (sw_raw),
        .sw_clean   (sw_clean),
        .sw_changed (sw_changed),
        .any_changed(any_changed)
    );

    typedef struct packed {
        logic [W-1:0] clean;
        logic [W-1:0] chg;
        logic         any;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: a bit is accepted once the last D synchronised samples
    // (the pin as seen two edges late) all disagree with the clean level.
    logic [W-1:0] m_s1, m_s2, m_clean, m_chg;
    logic         m_any;
    logic [W-1:0] m_hist[$];

    task automatic model_edge(input logic [W-1:0] raw, input logic rst);
        exp_t e;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_clean = '0; m_chg = '0; m_any = 1'b0;
            m_hist.delete();
        end else begin
            m_any = |m_chg;
            m_hist.push_back(m_s2);
            if (m_hist.size() > D) void'(m_hist.pop_front());
            m_chg = '0;
            if (m_hist.size() == D) begin
                for (int b = 0; b < W; b++) begin
                    bit all_diff = 1'b1;
                    for (int j = 0; j < D; j++)
                        if (m_hist[j][b] == m_clean[b]) all_diff = 1'b0;
                    m_chg[b] = all_diff;
                end
            end
            m_clean = m_clean ^ m_chg;
            m_s2 = m_s1;
            m_s1 = raw;
        end
        e.clean = m_clean;
        e.chg   = m_chg;
        e.any   = m_any;
        sb_q.push_back(e);
    endtask

    // Drive one cycle of stimulus, then record what the edge should produce.
    task automatic step(input logic [W-1:0] raw, input logic rst);
        sw_raw = raw;
        reset  = rst;
        @(posedge clk);
        model_edge(raw, rst);
        #1;
    endtask

    task automatic hold(input logic [W-1:0] raw, input int n);
        for (int i = 0; i < n; i++) step(raw, 1'b0);
    endtask

    // Monitor: outputs are valid every cycle; compare away from the edge.
    exp_t mon_e;
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            vectors++;
            if ({sw_clean, sw_changed, any_changed} !== mon_e) begin
                miscompares++;
                $display("FAIL vec%0d t=%0t: got clean=%h chg=%h any=%b, want clean=%h chg=%h any=%b",
                         vectors, $time, sw_clean, sw_changed, any_changed,
                         mon_e.clean, mon_e.chg, mon_e.any);
            end
        end
    end

    initial begin
        logic [W-1:0] cur;
        sw_raw = '0;
        reset  = 1'b1;

        // Reset with all pins high, then a clean single-bit step.
        for (int i = 0; i < 3; i++) step(9'h1FF, 1'b1);
        hold(9'h001, 10);
        hold(9'h000, 10);

        // Glitch of 3 cycles is rejected; 4 cycles is accepted.
        hold(9'h008, 3);
        hold(9'h000, 10);
        hold(9'h008, 4);
        hold(9'h000, 12);

        // Bounce on bit 8, then settle high.
        for (int i = 0; i < 10; i++) step((i % 2 == 0) ? 9'h100 : 9'h000, 1'b0);
        hold(9'h100, 10);
        hold(9'h000, 10);

        // Several bits together, then only bit 0 released.
        hold(9'h0A5, 8);
        hold(9'h0A4, 8);
        hold(9'h000, 10);

        // Reset lands mid-count on bit 2 while the pin stays high.
        hold(9'h004, 4);
        step(9'h004, 1'b1);
        hold(9'h004, 8);

        // Random bouncing: short and long pulses around the window length.
        cur = 9'h004;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < W; b++)
                if ($urandom_range(5) == 0) cur[b] = ~cur[b];
            step(cur, ($urandom_range(199) == 0));
        end
        hold(cur, 10);

        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors never checked, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
